switch_debounce3: RTL and testbench

Three-channel mechanical-switch conditioner placed directly upstream of the three-way lamp-control logic. It takes raw, bouncing, asynchronous wall-switch inputs and produces clean, clock-synchronous levels S1/S2/S3 that feed the lamp-control inputs. It also emits single-cycle rise, fall and any-change pulses for event counting and LED feedback.

---
 rtl/switch_debounce3.sv | 140 ++++++++++++++
 tb/tb_switch_debounce3.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce3.sv
// switch_debounce3: three-channel mechanical switch conditioner.
//
// Each raw, asynchronous switch input goes through a 2-flop synchronizer. A small
// STABLE/COUNTING FSM per channel then flips the debounced level once the
// synchronized input has disagreed with it for STABLE_CNT consecutive clocks.
// Registered one-cycle rise/fall/any-change pulses follow each flip by one cycle.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   sw_raw   raw switch inputs, bit0 = switch 1 .. bit2 = switch 3
//   S1..S3   debounced levels of sw_raw[0..2]
//   rise     one-cycle pulse per channel on a debounced 0->1
//   fall     one-cycle pulse per channel on a debounced 1->0
//   any_chg  OR of all rise/fall bits in the same cycle
module switch_debounce3 #(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned STABLE_CNT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_raw,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic [2:0] rise,
  output logic [2:0] fall,
  output logic       any_chg
);

  typedef enum logic {StStable, StCounting} state_e;

  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(STABLE_CNT - 1);
  // With a one-cycle window the first mismatch already satisfies the filter.
  localparam bit               NoFilter = (STABLE_CNT == 1);

  logic [2:0]       r_meta;
  logic [2:0]       r_sync;
  logic [2:0]       r_out;
  logic [2:0]       r_out_dly;
  logic [2:0]       r_rise;
  logic [2:0]       r_fall;
  logic             r_any;
  state_e           r_state   [3];
  state_e           w_state_d [3];
  logic [CNT_W-1:0] r_cnt     [3];
  logic [CNT_W-1:0] w_cnt_d   [3];
  logic [2:0]       w_out_d;
  logic [2:0]       w_mismatch;

  assign w_mismatch = r_sync ^ r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= sw_raw;
      r_sync <= r_meta;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_state_d[i] = r_state[i];
      w_cnt_d[i]   = r_cnt[i];
      w_out_d[i]   = r_out[i];
      unique case (r_state[i])
        StStable: begin
          w_cnt_d[i] = '0;
          if (w_mismatch[i]) begin
            if (NoFilter) begin
              w_out_d[i] = ~r_out[i];
            end else begin
              w_state_d[i] = StCounting;
              w_cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        StCounting: begin
          if (!w_mismatch[i]) begin
            // Bounce: discard the partial count entirely.
            w_state_d[i] = StStable;
            w_cnt_d[i]   = '0;
          end else if (r_cnt[i] >= LastCnt) begin
            w_out_d[i]   = ~r_out[i];
            w_state_d[i] = StStable;
            w_cnt_d[i]   = '0;
          end else begin
            w_cnt_d[i] = r_cnt[i] + 1'b1;
          end
        end
        default: begin
          w_state_d[i] = StStable;
          w_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= StStable;
        r_cnt[i]   <= '0;
      end
      r_out <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= w_state_d[i];
        r_cnt[i]   <= w_cnt_d[i];
      end
      r_out <= w_out_d;
    end
  end

  // Pulses are derived from the registered level and its delayed copy, so they
  // land one cycle after the level flips and can never overlap per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_dly <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_any     <= 1'b0;
    end else begin
      r_out_dly <= r_out;
      r_rise    <= r_out & ~r_out_dly;
      r_fall    <= ~r_out & r_out_dly;
      r_any     <= |(r_out ^ r_out_dly);
    end
  end

  assign S1      = r_out[0];
  assign S2      = r_out[1];
  assign S3      = r_out[2];
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign any_chg = r_any;

endmodule

// File: tb/tb_switch_debounce3.sv
module tb_switch_debounce3;

  localparam int N   = 4;
  localparam int LAT = 2 + N;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_raw;
  logic       S1, S2, S3;
  logic [2:0] rise, fall;
  logic       any_chg;
  logic [2:0] w_lvl;

  int n_checks = 0;
  int n_pass   = 0;

  switch_debounce3 #(
    .CNT_W     (20),
    .STABLE_CNT(N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .S1     (S1),
    .S2     (S2),
    .S3     (S3),
    .rise   (rise),
    .fall   (fall),
    .any_chg(any_chg)
  );

  assign w_lvl = {S3, S2, S1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a level flips once the input, seen through two sync
  // stages, has disagreed with it for N consecutive clock samples; the matching
  // pulse is reported on the following clock.
  logic [2:0] m_s1, m_s2, m_out, m_rise, m_fall, p_rise, p_fall;
  logic       m_any;
  int         m_run [3];
  logic [2:0] raw_prev;
  logic       rst_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      p_rise = '0; p_fall = '0; m_any = 1'b0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else if (rst_prev) begin
      m_rise = p_rise;
      m_fall = p_fall;
      m_any  = |(p_rise | p_fall);
      p_rise = '0;
      p_fall = '0;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == N) begin
            m_out[c] = ~m_out[c];
            if (m_out[c]) p_rise[c] = 1'b1;
            else          p_fall[c] = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_prev;
    end
    check("model_level", w_lvl, m_out);
    check("model_rise", rise, m_rise);
    check("model_fall", fall, m_fall);
    check("model_any", any_chg, m_any);
    raw_prev = sw_raw;
    rst_prev = rst_n;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expects channel ch to reach level nv exactly LAT edges after the input
  // change just driven, with a single correct pulse one cycle later.
  task automatic expect_toggle(input string name, input int ch, input logic nv);
    int   np;
    int   nq;
    logic exp_l;
    np = 0;
    nq = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick(1);
      exp_l = (k >= LAT) ? nv : !nv;
      check({name, "_lvl"}, w_lvl[ch], exp_l);
      if (k == LAT + 1) begin
        check({name, "_pulse"}, nv ? rise[ch] : fall[ch], 1);
        check({name, "_any"}, any_chg, 1);
      end
      np += nv ? int'(rise[ch]) : int'(fall[ch]);
      nq += nv ? int'(fall[ch]) : int'(rise[ch]);
    end
    check({name, "_npulse"}, np, 1);
    check({name, "_wrongpulse"}, nq, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 3'b000;
    tick(2);
    check("reset_zero", {w_lvl, rise, fall, any_chg}, 0);
    #2 rst_n = 1'b1;
    tick(20);
    check("reset_idle", {w_lvl, rise, fall, any_chg}, 0);

    // Clean press on switch 1, then release.
    sw_raw[0] = 1'b1;
    expect_toggle("press", 0, 1'b1);
    check("press_others", {S3, S2, fall}, 0);
    sw_raw[0] = 1'b0;
    expect_toggle("release0", 0, 1'b0);

    // Bounce on switch 2.
    for (int i = 0; i < 4; i++) begin
      sw_raw[1] = (i % 2 == 0);
      tick(2);
      check("bounce_S2", S2, 0);
    end
    sw_raw[1] = 1'b1;
    expect_toggle("bounce", 1, 1'b1);
    sw_raw[1] = 1'b0;
    expect_toggle("release1", 1, 1'b0);

    // Switch 3 on then off.
    sw_raw[2] = 1'b1;
    expect_toggle("s3_on", 2, 1'b1);
    sw_raw[2] = 1'b0;
    expect_toggle("s3_off", 2, 1'b0);

    // Simultaneous rise on all channels.
    sw_raw = 3'b111;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick(1);
      if (k == LAT - 1) check("simul_before", w_lvl, 3'b000);
      if (k == LAT)     check("simul_level", w_lvl, 3'b111);
      if (k == LAT + 1) check("simul_pulse", {rise, fall, any_chg}, 7'b111_000_1);
      if (k == LAT + 2) check("simul_after", {rise, fall, any_chg}, 0);
    end

    // Walk every input code.
    for (int c = 0; c < 8; c++) begin
      sw_raw = c[2:0];
      tick(50);
      check("walk", w_lvl, c);
    end

    // Reset in the middle of a count.
    sw_raw = 3'b000;
    tick(12);
    sw_raw[0] = 1'b1;
    tick(5);
    #2 rst_n = 1'b0;
    #1 check("midcnt_rst", {w_lvl, rise, fall, any_chg}, 0);
    tick(3);
    check("midcnt_hold", {w_lvl, rise, fall, any_chg}, 0);
    #2 rst_n = 1'b1;
    expect_toggle("rst_rel", 0, 1'b1);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
